alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Shares the single combinational ALU between two requesters: the EX-stage issue port (r0) and the address-generation/branch-resolve port (r1).
- Arbitrates round-robin, drives the ALU with the granted operands and registers the result in one output stage with a valid/ready handshake.
- Sits between ID/EX and EX/MEM; the ALU is instantiated inside with enable tied high while a grant is active.

Parameters:
- DSize, 32, operand and result width.
- OSize, 3, ALU op MSB index; op width is OSize+1.
- CNT_W, 16, width of the per-requester saturating grant counters.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- r0_valid  input  1  requester 0 has an operation
- r0_ready  output  1  requester 0 operation accepted this cycle
- r0_op  input  OSize+1  ALU opcode, r0
- r0_src1, r0_src2, r0_src3  input  DSize each  operands, r0
- r0_sv  input  2  load/store scale, r0
- r1_valid, r1_ready, r1_op, r1_src1, r1_src2, r1_src3, r1_sv  same as r0 for requester 1
- res_valid  output  1  registered result valid
- res_ready  input  1  consumer accepts the result
- res_id  output  1  requester that issued the result (0/1)
- res_data  output  DSize  ALU alu_result
- res_overflow  output  1  ALU overflow
- res_branch  output  1  ALU branch_true
- gnt_cnt0, gnt_cnt1  output  CNT_W each  saturating accepted-operation counts

Behaviour:
- Reset (rst=1 at an edge): res_valid=0, res_id=0, res_data=0, res_overflow=0, res_branch=0, gnt_cnt0=gnt_cnt1=0, last_gnt=1. Reset mid-transaction discards the held result with no completion.
- Stage free when res_valid=0 or res_ready=1 (pipelined: accept and drain in the same cycle).
- Grant (combinational, from the current cycle's state):
  - Stage not free: no grant; r0_ready=r1_ready=0.
  - Only rX_valid high: grant X.
  - Both valid: grant the requester not equal to last_gnt.
  - Neither valid: no grant.
- rX_ready=1 exactly when X is granted. Requesters must not make rX_valid depend on rX_ready. Once asserted, valid and payload must hold until accepted.
- ALU inputs are muxed from the granted requester, with enable=1 on grant. With no grant, enable=0 and the mux selects r0.
- On a grant edge:
  - res_valid<=1, res_id<=X, and res_data/res_overflow/res_branch <= ALU outputs.
  - last_gnt<=X.
  - gnt_cntX increments, saturating at all-ones.
- Stage free and no grant: res_valid<=0; the res_* payload holds its value (don't-care).
- Stage not free (res_valid=1, res_ready=0): every output holds; last_gnt holds.
- Latency: one cycle from acceptance to res_valid. Throughput: one operation per cycle while res_ready=1.
- Fairness: under continuous dual requests, grants strictly alternate. A requester never waits more than one accepted operation of the other.
- ALU function per opcode, unchanged:
  - 0000 add, 0001 sub (signed overflow flagged).
  - 0010 and, 0011 or, 0100 xor.
  - 0101 srl, 0110 sll, 0111 rotate right by src2%32.
  - 1001 src1+(src2<<sv), 1010 src1+(src2<<2).
  - 1011 beq, 1100 bne, 1101 bz, 1110 bnz, all on src3; 1111 jump (branch_true=1). Branch ops return data 0.
  - 1000 gives all zero.

Test Plan:
- Reset then r0 only: r0_op=0000, src1=5, src2=7, res_ready=1 -> r0_ready=1 that cycle. Next cycle res_valid=1, res_id=0, res_data=12, overflow=0. gnt_cnt0=1.
- Both valid every cycle for 4 cycles, res_ready=1 -> grant order r0,r1,r0,r1. res_id sequence 0,1,0,1. gnt_cnt0=gnt_cnt1=2.
- Backpressure: result held with res_ready=0 for 3 cycles while r1 is valid -> r1_ready=0 throughout and res_* stable. On the res_ready=1 cycle, r1 is accepted and the new result appears next cycle.
- Overflow/branch: r1 op 0000, src1=32'h7FFFFFFF, src2=1 -> res_data=32'h80000000, res_overflow=1. Then r1 op 1011, src1=src3=9 -> res_branch=1, res_data=0.
- Counter saturation with CNT_W=2 -> 5 r0 accepts give gnt_cnt0=3.
- Reset asserted while res_valid=1 and res_ready=0 -> next cycle res_valid=0, counters 0. The first later dual request is granted to r0.

Source files
------------

// File: rtl/alu_share_arb.sv
// Round-robin arbiter that shares one combinational ALU between the EX issue port (r0)
// and the address/branch port (r1), with a single registered valid/ready result stage.

module alu_share_alu #(
    parameter int DSize = 32,
    parameter int OSize = 3
) (
    input  logic             enable,
    input  logic [OSize:0]   op,
    input  logic [DSize-1:0] src1,
    input  logic [DSize-1:0] src2,
    input  logic [DSize-1:0] src3,
    input  logic [1:0]       sv,
    output logic [DSize-1:0] alu_result,
    output logic             overflow,
    output logic             branch_true
);
    localparam int SH_W = $clog2(DSize);

    localparam logic [OSize:0] OP_ADD  = (OSize+1)'(0);
    localparam logic [OSize:0] OP_SUB  = (OSize+1)'(1);
    localparam logic [OSize:0] OP_AND  = (OSize+1)'(2);
    localparam logic [OSize:0] OP_OR   = (OSize+1)'(3);
    localparam logic [OSize:0] OP_XOR  = (OSize+1)'(4);
    localparam logic [OSize:0] OP_SRL  = (OSize+1)'(5);
    localparam logic [OSize:0] OP_SLL  = (OSize+1)'(6);
    localparam logic [OSize:0] OP_ROR  = (OSize+1)'(7);
    localparam logic [OSize:0] OP_AGS  = (OSize+1)'(9);
    localparam logic [OSize:0] OP_AGW  = (OSize+1)'(10);
    localparam logic [OSize:0] OP_BEQ  = (OSize+1)'(11);
    localparam logic [OSize:0] OP_BNE  = (OSize+1)'(12);
    localparam logic [OSize:0] OP_BZ   = (OSize+1)'(13);
    localparam logic [OSize:0] OP_BNZ  = (OSize+1)'(14);
    localparam logic [OSize:0] OP_JMP  = (OSize+1)'(15);

    logic [SH_W-1:0]    shamt;
    logic [DSize-1:0]   sum;
    logic [DSize-1:0]   diff;
    logic [2*DSize-1:0] rot_wide;

    assign shamt    = src2[SH_W-1:0];
    assign sum      = src1 + src2;
    assign diff     = src1 - src2;
    assign rot_wide = {src1, src1} >> shamt;

    always_comb begin
        alu_result  = '0;
        overflow    = 1'b0;
        branch_true = 1'b0;
        if (enable) begin
            case (op)
                OP_ADD: begin
                    alu_result = sum;
                    overflow   = (src1[DSize-1] == src2[DSize-1]) && (sum[DSize-1] != src1[DSize-1]);
                end
                OP_SUB: begin
                    alu_result = diff;
                    overflow   = (src1[DSize-1] != src2[DSize-1]) && (diff[DSize-1] != src1[DSize-1]);
                end
                OP_AND: alu_result = src1 & src2;
                OP_OR:  alu_result = src1 | src2;
                OP_XOR: alu_result = src1 ^ src2;
                OP_SRL: alu_result = src1 >> shamt;
                OP_SLL: alu_result = src1 << shamt;
                OP_ROR: alu_result = rot_wide[DSize-1:0];
                OP_AGS: alu_result = src1 + (src2 << sv);
                OP_AGW: alu_result = src1 + (src2 << 2);
                OP_BEQ: branch_true = (src1 == src3);
                OP_BNE: branch_true = (src1 != src3);
                OP_BZ:  branch_true = (src3 == '0);
                OP_BNZ: branch_true = (src3 != '0);
                OP_JMP: branch_true = 1'b1;
                default: alu_result = '0;
            endcase
        end
    end
endmodule

module alu_share_arb #(
    parameter int DSize = 32,
    parameter int OSize = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [OSize:0]   r0_op,
    input  logic [DSize-1:0] r0_src1,
    input  logic [DSize-1:0] r0_src2,
    input  logic [DSize-1:0] r0_src3,
    input  logic [1:0]       r0_sv,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [OSize:0]   r1_op,
    input  logic [DSize-1:0] r1_src1,
    input  logic [DSize-1:0] r1_src2,
    input  logic [DSize-1:0] r1_src3,
    input  logic [1:0]       r1_sv,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [DSize-1:0] res_data,
    output logic             res_overflow,
    output logic             res_branch,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);
    logic             last_gnt;
    logic             stage_free;
    logic             gnt_r0;
    logic             gnt_r1;
    logic             alu_en;
    logic [OSize:0]   alu_op;
    logic [DSize-1:0] alu_src1;
    logic [DSize-1:0] alu_src2;
    logic [DSize-1:0] alu_src3;
    logic [1:0]       alu_sv;
    logic [DSize-1:0] alu_result;
    logic             alu_overflow;
    logic             alu_branch;

    // On a tie the requester that did not win last time takes the ALU.
    assign stage_free = !res_valid || res_ready;
    assign gnt_r0     = stage_free && r0_valid && (!r1_valid || last_gnt);
    assign gnt_r1     = stage_free && r1_valid && (!r0_valid || !last_gnt);
    assign r0_ready   = gnt_r0;
    assign r1_ready   = gnt_r1;
    assign alu_en     = gnt_r0 || gnt_r1;

    assign alu_op   = gnt_r1 ? r1_op   : r0_op;
    assign alu_src1 = gnt_r1 ? r1_src1 : r0_src1;
    assign alu_src2 = gnt_r1 ? r1_src2 : r0_src2;
    assign alu_src3 = gnt_r1 ? r1_src3 : r0_src3;
    assign alu_sv   = gnt_r1 ? r1_sv   : r0_sv;

    alu_share_alu #(.DSize(DSize), .OSize(OSize)) u_alu (
        .enable      (alu_en),
        .op          (alu_op),
        .src1        (alu_src1),
        .src2        (alu_src2),
        .src3        (alu_src3),
        .sv          (alu_sv),
        .alu_result  (alu_result),
        .overflow    (alu_overflow),
        .branch_true (alu_branch)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid    <= 1'b0;
            res_id       <= 1'b0;
            res_data     <= '0;
            res_overflow <= 1'b0;
            res_branch   <= 1'b0;
            gnt_cnt0     <= '0;
            gnt_cnt1     <= '0;
            last_gnt     <= 1'b1;
        end else if (alu_en) begin
            res_valid    <= 1'b1;
            res_id       <= gnt_r1;
            res_data     <= alu_result;
            res_overflow <= alu_overflow;
            res_branch   <= alu_branch;
            last_gnt     <= gnt_r1;
            if (gnt_r0 && (gnt_cnt0 != '1)) gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
            if (gnt_r1 && (gnt_cnt1 != '1)) gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
        end else if (stage_free) begin
            res_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: arbitration order, backpressure, ALU ops,
// counter saturation (second instance with 2-bit counters) and reset recovery.

module tb_alu_share_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r1_valid, res_ready;
    logic [3:0]  r0_op, r1_op;
    logic [31:0] r0_src1, r0_src2, r0_src3, r1_src1, r1_src2, r1_src3;
    logic [1:0]  r0_sv, r1_sv;
    logic        r0_ready, r1_ready, res_valid, res_id, res_overflow, res_branch;
    logic [31:0] res_data;
    logic [15:0] gnt_cnt0, gnt_cnt1;
    logic        s_r0_ready, s_r1_ready, s_res_valid, s_res_id, s_res_overflow, s_res_branch;
    logic [31:0] s_res_data;
    logic [1:0]  s_gnt_cnt0, s_gnt_cnt1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, c;
        logic [1:0]  sv;
        logic [31:0] d;
        logic        ovf, br;
    } vec_t;

    always #5 clk = ~clk;

    alu_share_arb dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op),
        .r0_src1(r0_src1), .r0_src2(r0_src2), .r0_src3(r0_src3), .r0_sv(r0_sv),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op),
        .r1_src1(r1_src1), .r1_src2(r1_src2), .r1_src3(r1_src3), .r1_sv(r1_sv),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_data(res_data), .res_overflow(res_overflow), .res_branch(res_branch),
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    alu_share_arb #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(s_r0_ready), .r0_op(r0_op),
        .r0_src1(r0_src1), .r0_src2(r0_src2), .r0_src3(r0_src3), .r0_sv(r0_sv),
        .r1_valid(r1_valid), .r1_ready(s_r1_ready), .r1_op(r1_op),
        .r1_src1(r1_src1), .r1_src2(r1_src2), .r1_src3(r1_src3), .r1_sv(r1_sv),
        .res_valid(s_res_valid), .res_ready(res_ready), .res_id(s_res_id),
        .res_data(s_res_data), .res_overflow(s_res_overflow), .res_branch(s_res_branch),
        .gnt_cnt0(s_gnt_cnt0), .gnt_cnt1(s_gnt_cnt1)
    );

    // Inputs change 1 time unit after the rising edge; combinational outputs are
    // sampled 2 units later, registered ones 1 unit after the next edge.
    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        next_edge();
        next_edge();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (res_valid !== 1'b0 || res_id !== 1'b0 || res_data !== 32'h0 ||
            res_overflow !== 1'b0 || res_branch !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b id=%b data=%h ovf=%b br=%b, want all 0",
                     res_valid, res_id, res_data, res_overflow, res_branch);
        end
        checks++;
        if (gnt_cnt0 !== 16'd0 || gnt_cnt1 !== 16'd0) begin
            failures++;
            $display("FAIL reset_counters: got %0d/%0d, want 0/0", gnt_cnt0, gnt_cnt1);
        end
    endtask

    task automatic test_r0_only();
        res_ready = 1'b1;
        r0_valid = 1'b1; r0_op = 4'h0; r0_src1 = 32'd5; r0_src2 = 32'd7;
        #2;
        checks++;
        if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
            failures++;
            $display("FAIL r0_only_ready: got r0=%b r1=%b, want 1/0", r0_ready, r1_ready);
        end
        next_edge();
        r0_valid = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || res_id !== 1'b0 || res_data !== 32'd12 || res_overflow !== 1'b0) begin
            failures++;
            $display("FAIL r0_only_result: got valid=%b id=%b data=%0d ovf=%b, want 1/0/12/0",
                     res_valid, res_id, res_data, res_overflow);
        end
        checks++;
        if (gnt_cnt0 !== 16'd1) begin
            failures++;
            $display("FAIL r0_only_cnt: got %0d, want 1", gnt_cnt0);
        end
    endtask

    task automatic test_round_robin();
        logic        exp_id;
        logic [31:0] exp_data;
        do_reset();
        res_ready = 1'b1;
        r0_op = 4'h0; r0_src1 = 32'd1;  r0_src2 = 32'd2;
        r1_op = 4'h1; r1_src1 = 32'd10; r1_src2 = 32'd4;
        r0_valid = 1'b1; r1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_id   = (i % 2) == 1;
            exp_data = exp_id ? 32'd6 : 32'd3;
            #2;
            checks++;
            if (r0_ready !== !exp_id || r1_ready !== exp_id) begin
                failures++;
                $display("FAIL rr_grant[%0d]: got r0=%b r1=%b, want r%0d", i, r0_ready, r1_ready, exp_id);
            end
            @(posedge clk); #1;
            checks++;
            if (res_valid !== 1'b1 || res_id !== exp_id || res_data !== exp_data) begin
                failures++;
                $display("FAIL rr_result[%0d]: got valid=%b id=%b data=%0d, want 1/%b/%0d",
                         i, res_valid, res_id, res_data, exp_id, exp_data);
            end
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        checks++;
        if (gnt_cnt0 !== 16'd2 || gnt_cnt1 !== 16'd2) begin
            failures++;
            $display("FAIL rr_counts: got %0d/%0d, want 2/2", gnt_cnt0, gnt_cnt1);
        end
        next_edge();
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL rr_drain: got res_valid=%b, want 0", res_valid);
        end
    endtask

    task automatic test_backpressure();
        res_ready = 1'b1;
        r0_valid = 1'b1; r0_op = 4'h2; r0_src1 = 32'h0000_00F0; r0_src2 = 32'h0000_003C;
        next_edge();
        r0_valid = 1'b0;
        res_ready = 1'b0;
        r1_valid = 1'b1; r1_op = 4'h3; r1_src1 = 32'h0000_0100; r1_src2 = 32'h0000_0001;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (r1_ready !== 1'b0 || r0_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_ready[%0d]: got r0=%b r1=%b, want 0/0", i, r0_ready, r1_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (res_valid !== 1'b1 || res_id !== 1'b0 || res_data !== 32'h30) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got valid=%b id=%b data=%h, want 1/0/00000030",
                         i, res_valid, res_id, res_data);
            end
        end
        res_ready = 1'b1;
        #2;
        checks++;
        if (r1_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready: got r1_ready=%b, want 1", r1_ready);
        end
        @(posedge clk); #1;
        r1_valid = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || res_id !== 1'b1 || res_data !== 32'h101) begin
            failures++;
            $display("FAIL bp_release_result: got valid=%b id=%b data=%h, want 1/1/00000101",
                     res_valid, res_id, res_data);
        end
    endtask

    task automatic test_overflow_branch();
        res_ready = 1'b1;
        r1_valid = 1'b1; r1_op = 4'h0; r1_src1 = 32'h7FFF_FFFF; r1_src2 = 32'h1; r1_src3 = 32'h0; r1_sv = 2'd0;
        next_edge();
        checks++;
        if (res_id !== 1'b1 || res_data !== 32'h8000_0000 || res_overflow !== 1'b1 || res_branch !== 1'b0) begin
            failures++;
            $display("FAIL add_overflow: got id=%b data=%h ovf=%b br=%b, want 1/80000000/1/0",
                     res_id, res_data, res_overflow, res_branch);
        end
        r1_op = 4'hB; r1_src1 = 32'd9; r1_src2 = 32'd1; r1_src3 = 32'd9;
        next_edge();
        r1_valid = 1'b0;
        checks++;
        if (res_id !== 1'b1 || res_data !== 32'h0 || res_overflow !== 1'b0 || res_branch !== 1'b1) begin
            failures++;
            $display("FAIL beq_taken: got id=%b data=%h ovf=%b br=%b, want 1/0/0/1",
                     res_id, res_data, res_overflow, res_branch);
        end
    endtask

    task automatic test_alu_ops();
        vec_t vecs[12];
        vecs[0]  = '{4'h1, 32'h8000_0000, 32'h1,         32'h0, 2'd0, 32'h7FFF_FFFF, 1'b1, 1'b0};
        vecs[1]  = '{4'h4, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 2'd0, 32'h0000_0FF0, 1'b0, 1'b0};
        vecs[2]  = '{4'h5, 32'h8000_0000, 32'd4,         32'h0, 2'd0, 32'h0800_0000, 1'b0, 1'b0};
        vecs[3]  = '{4'h6, 32'h1,         32'd4,         32'h0, 2'd0, 32'h10,        1'b0, 1'b0};
        vecs[4]  = '{4'h7, 32'h1,         32'd33,        32'h0, 2'd0, 32'h8000_0000, 1'b0, 1'b0};
        vecs[5]  = '{4'h9, 32'd100,       32'd5,         32'h0, 2'd3, 32'd140,       1'b0, 1'b0};
        vecs[6]  = '{4'hA, 32'd100,       32'd5,         32'h0, 2'd3, 32'd120,       1'b0, 1'b0};
        vecs[7]  = '{4'hC, 32'd9,         32'd0,         32'd8, 2'd0, 32'h0,         1'b0, 1'b1};
        vecs[8]  = '{4'hD, 32'd9,         32'd0,         32'd0, 2'd0, 32'h0,         1'b0, 1'b1};
        vecs[9]  = '{4'hE, 32'd9,         32'd0,         32'd0, 2'd0, 32'h0,         1'b0, 1'b0};
        vecs[10] = '{4'hF, 32'd9,         32'd7,         32'd3, 2'd0, 32'h0,         1'b0, 1'b1};
        vecs[11] = '{4'h8, 32'd5,         32'd7,         32'd3, 2'd1, 32'h0,         1'b0, 1'b0};
        res_ready = 1'b1;
        r1_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            r0_valid = 1'b1;
            r0_op = vecs[i].op; r0_src1 = vecs[i].a; r0_src2 = vecs[i].b;
            r0_src3 = vecs[i].c; r0_sv = vecs[i].sv;
            next_edge();
            checks++;
            if (res_valid !== 1'b1 || res_data !== vecs[i].d ||
                res_overflow !== vecs[i].ovf || res_branch !== vecs[i].br) begin
                failures++;
                $display("FAIL alu_op[%0d] op=%h: got valid=%b data=%h ovf=%b br=%b, want 1/%h/%b/%b",
                         i, vecs[i].op, res_valid, res_data, res_overflow, res_branch,
                         vecs[i].d, vecs[i].ovf, vecs[i].br);
            end
        end
        r0_valid = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        res_ready = 1'b1;
        r0_valid = 1'b1; r0_op = 4'h0; r0_src1 = 32'd1; r0_src2 = 32'd1;
        for (int i = 0; i < 5; i++) next_edge();
        r0_valid = 1'b0;
        checks++;
        if (s_gnt_cnt0 !== 2'd3 || s_gnt_cnt1 !== 2'd0) begin
            failures++;
            $display("FAIL sat_cnt_w2: got %0d/%0d, want 3/0", s_gnt_cnt0, s_gnt_cnt1);
        end
        checks++;
        if (gnt_cnt0 !== 16'd5) begin
            failures++;
            $display("FAIL sat_cnt_w16: got %0d, want 5", gnt_cnt0);
        end
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b1;
        r0_valid = 1'b1; r1_valid = 1'b1; r0_op = 4'h0; r1_op = 4'h0;
        next_edge();
        r0_valid = 1'b0; r1_valid = 1'b0;
        res_ready = 1'b0;
        next_edge();
        rst = 1'b1;
        next_edge();
        rst = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || gnt_cnt0 !== 16'd0 || gnt_cnt1 !== 16'd0) begin
            failures++;
            $display("FAIL mid_reset: got valid=%b cnt=%0d/%0d, want 0/0/0", res_valid, gnt_cnt0, gnt_cnt1);
        end
        res_ready = 1'b1;
        r0_valid = 1'b1; r1_valid = 1'b1;
        #2;
        checks++;
        if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_grant: got r0=%b r1=%b, want 1/0", r0_ready, r1_ready);
        end
        @(posedge clk); #1;
        r0_valid = 1'b0; r1_valid = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || res_id !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_result: got valid=%b id=%b, want 1/0", res_valid, res_id);
        end
    endtask

    initial begin
        rst = 1'b1; res_ready = 1'b0;
        r0_valid = 1'b0; r0_op = 4'h0; r0_src1 = '0; r0_src2 = '0; r0_src3 = '0; r0_sv = 2'd0;
        r1_valid = 1'b0; r1_op = 4'h0; r1_src1 = '0; r1_src2 = '0; r1_src3 = '0; r1_sv = 2'd0;
        #1;
        test_reset();
        test_r0_only();
        test_round_robin();
        test_backpressure();
        test_overflow_branch();
        test_alu_ops();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
